rr_arb4_stage: RTL and testbench
================================

Name: rr_arb4_stage

Overview:
- Four-channel round-robin arbiter with output register. Sits directly upstream of the 4:1 mux datapath.
- Picks one of four valid/ready source channels per cycle and drives the 2-bit select that steers the mux4 tree.
- Captures the selected word in an output register with a valid/ready handshake toward the consumer.
- Provides fair sharing of one WIDTH-bit link among four producers.

Parameters:
- WIDTH, 8, data width of every channel and of the output register (must be >= 1).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-channel request; bit i belongs to channel i.
- in_ready  output  4  per-channel accept; one-hot or zero.
- a  input  WIDTH  channel 0 data.
- b  input  WIDTH  channel 1 data.
- c  input  WIDTH  channel 2 data.
- d  input  WIDTH  channel 3 data.
- sel  output  2  mux select; s[0] picks a/b and c/d, s[1] picks low/high; encodes channel index 0..3.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  WIDTH  registered selected word.
- out_src  output  2  channel index that produced out_data.

Behaviour:
- Reset (async, active-high, takes effect immediately):
  - out_valid=0, out_data=0, out_src=0.
  - Priority pointer ptr=0, so channel 0 has highest priority first.
  - in_ready=0 while rst=1.
- load_en = !out_valid | out_ready. The register is empty or drains this cycle.
- Winner selection (combinational):
  - Scan channels ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - The first channel with in_valid=1 wins.
- sel:
  - Equals the winner index when any in_valid=1.
  - Otherwise equals ptr.
  - sel is combinational and valid in the same cycle.
- in_ready[i]=1 only when load_en=1, channel i is the winner, and rst=0. All other bits are 0.
  - in_ready depends combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- Accept event: in_valid[i] & in_ready[i]. On the next rising edge:
  - out_data <= word of channel i (the mux4 output for sel=i).
  - out_src <= i.
  - out_valid <= 1.
  - ptr <= (i+1) mod 4.
- Drain without accept: out_valid & out_ready with no winner. On the next edge out_valid <= 0; out_data and out_src hold their values.
- Stall: out_valid & !out_ready. out_data, out_src and ptr hold; in_ready=0.
- Simultaneous drain and accept:
  - The new word is loaded in the same edge. out_valid stays 1.
  - Sustained throughput is 1 word/cycle with no bubble.
- Latency: accept edge to out_valid=1 is 1 cycle.
- Fairness:
  - With all four channels continuously valid and out_ready=1, grants follow 0,1,2,3,0,...
  - Any continuously valid channel is granted within 4 accepts.
- ptr changes only on an accept. Idle cycles do not rotate priority.
- Reset mid-transfer:
  - A pending out_valid word is discarded.
  - ptr returns to 0.
  - No in_ready pulse occurs while rst is high.
- Arithmetic: ptr and indices are 2-bit and wrap naturally (3+1=0).

Test Plan:
- Reset: rst=1 with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, sel=0. Release rst -> first grant goes to channel 0 (in_ready=0001).
- Single channel: in_valid=0100, c=8'hA5, out_ready=1 -> in_ready=0100 and sel=2. Next cycle out_valid=1, out_data=8'hA5, out_src=2, ptr=3.
- Full contention: in_valid=1111 with a/b/c/d = 11/22/33/44, out_ready=1, run 8 cycles -> out_data sequence 11,22,33,44,11,22,33,44; out_valid continuously 1 after the first cycle.
- Backpressure: word held with out_ready=0 for 3 cycles while in_valid=1111 -> in_ready=0000, and out_data/out_src stable. When out_ready=1, the next channel in rotation is accepted the same cycle with no bubble.
- Skip and wrap: ptr=3 and in_valid=0010 -> channel 1 granted, sel=1, then ptr=2. Next in_valid=1001 -> channel 3 granted before 0.
- Async reset mid-stream: assert rst between edges while out_valid=1 -> out_valid=0 immediately, not at the next edge. After release, in_valid=1111 grants channel 0.

Source files
------------

// File: rtl/rr_arb4_stage.sv
// Four-channel round-robin arbiter feeding a registered valid/ready output stage.
// The combinational select drives the downstream mux4 tree; the chosen word is
// captured in the output register on the accept edge.
module rr_arb4_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src
);

  logic [1:0]       ptr;
  logic [1:0]       winner;
  logic [1:0]       idx;
  logic             any_valid;
  logic             load_en;
  logic             accept;
  logic [WIDTH-1:0] mux_word;

  // Rotating-priority scan: first requesting channel at or after ptr wins
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!any_valid && in_valid[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

  // Register may take a new word when empty or draining this cycle
  assign load_en = !out_valid || out_ready;
  assign accept  = load_en && any_valid && !rst;

  // With no requester the select parks on the current priority pointer
  assign sel = any_valid ? winner : ptr;

  // One-hot grant to the winner only when a load can happen
  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready[winner] = 1'b1;
    end
  end

  // mux4 tree: sel[0] picks within a pair, sel[1] picks the pair
  always_comb begin
    mux_word = '0;
    case (sel)
      2'd0:    mux_word = a;
      2'd1:    mux_word = b;
      2'd2:    mux_word = c;
      default: mux_word = d;
    endcase
  end

  // Output register, source tag and priority pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mux_word;
      out_src   <= winner;
      ptr       <= winner + 2'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb4_stage.sv
// Self-checking bench for rr_arb4_stage: directed scenarios plus randomized
// traffic compared against a behavioural round-robin model.
module tb_rr_arb4_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_valid = '0;
  logic [3:0] in_ready;
  logic [7:0] a = '0, b = '0, c = '0, d = '0;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] out_src;

  int errors = 0;
  int checks = 0;

  // model state
  int         m_ptr = 0;
  bit         m_valid = 0;
  logic [7:0] m_data = '0;
  int         m_src = 0;

  rr_arb4_stage #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .sel(sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_src(out_src)
  );

  always #5 clk = ~clk;

  function automatic int m_winner(input int p, input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [7:0] m_word(input int ch);
    case (ch)
      0: return a;
      1: return b;
      2: return c;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] m_ready();
    int w;
    logic [3:0] r;
    w = m_winner(m_ptr, in_valid);
    r = '0;
    if (!rst && (!m_valid || out_ready) && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic logic [1:0] m_sel();
    int w;
    w = m_winner(m_ptr, in_valid);
    return (w >= 0) ? 2'(w) : 2'(m_ptr);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0;
  endtask

  task automatic apply(input logic [3:0] v, input logic ordy);
    in_valid  = v;
    out_ready = ordy;
    #1;
  endtask

  // advance one clock edge, stepping the model with the inputs in effect
  task automatic tick();
    int w;
    w = m_winner(m_ptr, in_valid);
    if (!rst) begin
      if ((!m_valid || out_ready) && w >= 0) begin
        m_valid = 1; m_data = m_word(w); m_src = w; m_ptr = (w + 1) % 4;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    apply(4'b1111, 1'b1);
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_held got in_ready=%b out_valid=%b exp 0000/0", in_ready, out_valid); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b exp=0001", in_ready); end
  endtask

  task automatic test_single();
    c = 8'hA5;
    apply(4'b0100, 1'b1);
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_in_ready got=%b exp=0100", in_ready); end
    checks++; if (sel !== 2'd2) begin errors++; $display("FAIL single_sel got=%0d exp=2", sel); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd2) begin errors++; $display("FAIL single_out got v=%b d=%h s=%0d exp 1/a5/2", out_valid, out_data, out_src); end
    apply(4'b1111, 1'b1);
    checks++; if (sel !== 2'd3) begin errors++; $display("FAIL single_ptr got sel=%0d exp=3", sel); end
  endtask

  task automatic test_contention();
    logic [7:0] seq [4];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
    do_reset();
    a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
    apply(4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL contention_ready[%0d] got=%b exp=%b", i, in_ready, m_ready()); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== seq[i % 4]) begin errors++; $display("FAIL contention_data[%0d] got v=%b d=%h exp 1/%h", i, out_valid, out_data, seq[i % 4]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held_d;
    logic [1:0] held_s;
    held_d = out_data;
    held_s = out_src;
    apply(4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== held_d || out_src !== held_s) begin errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h s=%0d exp 1/%h/%0d", i, out_valid, out_data, out_src, held_d, held_s); end
    end
    apply(4'b1111, 1'b1);
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_ready got=%b exp=0001", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_src !== 2'd0) begin errors++; $display("FAIL bp_release_out got v=%b d=%h s=%0d exp 1/11/0", out_valid, out_data, out_src); end
  endtask

  task automatic test_skip_wrap();
    do_reset();
    apply(4'b0100, 1'b1);
    tick();
    apply(4'b0010, 1'b1);
    checks++; if (sel !== 2'd1 || in_ready !== 4'b0010) begin errors++; $display("FAIL wrap_grant1 got sel=%0d rdy=%b exp 1/0010", sel, in_ready); end
    tick();
    apply(4'b1001, 1'b1);
    checks++; if (sel !== 2'd3 || in_ready !== 4'b1000) begin errors++; $display("FAIL wrap_grant3 got sel=%0d rdy=%b exp 3/1000", sel, in_ready); end
    tick();
    checks++; if (out_src !== 2'd3 || out_data !== 8'h44) begin errors++; $display("FAIL wrap_out got s=%0d d=%h exp 3/44", out_src, out_data); end
  endtask

  task automatic test_async_reset();
    apply(4'b1111, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got v=%b exp=1", out_valid); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_data !== 8'h00) begin errors++; $display("FAIL arst_immediate got v=%b rdy=%b d=%h exp 0/0000/00", out_valid, in_ready, out_data); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    apply(4'b1111, 1'b1);
    checks++; if (in_ready !== 4'b0001 || sel !== 2'd0) begin errors++; $display("FAIL arst_after got rdy=%b sel=%0d exp 0001/0", in_ready, sel); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      apply(4'($urandom), ($urandom_range(0, 3) != 0));
      checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, in_ready, m_ready()); end
      checks++; if (sel !== m_sel()) begin errors++; $display("FAIL rand_sel[%0d] got=%0d exp=%0d", i, sel, m_sel()); end
      tick();
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, out_valid, m_valid); end
      if (m_valid) begin
        checks++; if (out_data !== m_data || out_src !== 2'(m_src)) begin errors++; $display("FAIL rand_out[%0d] got d=%h s=%0d exp %h/%0d", i, out_data, out_src, m_data, m_src); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_skip_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
